// File: rtl/seq_serializer.sv
// seq_serializer: loads a 1..W bit word via valid/ready and shifts it out MSB-first, optionally looping.
module seq_serializer #(
  parameter int W  = 16,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  data,
  input  logic [LW-1:0] len,
  input  logic          loop,
  input  logic          stop,
  output logic          dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d, word_q, word_d;
  logic [LW-1:0] cnt_q, cnt_d, rld_q, rld_d, n, sh;
  logic          loop_q, loop_d, err_q, err_d, last, accept;
  // The word is left-aligned on capture so the MSB of the shift register is always the next bit.
  always_comb begin
    n          = (len > LW'(W)) ? LW'(W) : len;
    sh         = LW'(W) - n;
    last       = (state_q == SHIFT) && (cnt_q == '0);
    done       = last && (!loop_q || stop);
    load_ready = (state_q == IDLE) || done;
    accept     = load_valid && load_ready;
    dout_valid = (state_q == SHIFT);
    busy       = dout_valid;
    dout       = dout_valid & sr_q[W-1];
    err        = err_q;
    state_d    = state_q;
    sr_d       = sr_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    rld_d      = rld_q;
    loop_d     = loop_q;
    err_d      = accept && (n == '0);
    if (accept && n != '0) begin
      state_d = SHIFT;
      sr_d    = data << sh;
      word_d  = data << sh;
      cnt_d   = n - 1'b1;
      rld_d   = n - 1'b1;
      loop_d  = loop;
    end else if (last && !done) begin
      sr_d  = word_q;
      cnt_d = rld_q;
    end else if (last) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      rld_q   <= '0;
      loop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed checks of seq_serializer streams, looping, len edge cases and async reset.
module tb_seq_serializer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load_valid = 1'b0, loop = 1'b0, stop = 1'b0;
  logic [15:0] data = '0;
  logic [4:0]  len = '0;
  logic        load_ready, dout, dout_valid, busy, done, err;
  int          n_chk = 0, n_fail = 0;
  seq_serializer #(.W(16), .LW(5)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .data(data), .len(len), .loop(loop), .stop(stop), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [15:0] d, input logic [4:0] l, input logic lp);
    data = d; len = l; loop = lp; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; loop = 1'b0;
  endtask
  task automatic run(input logic [31:0] e, input int n, input logic [31:0] dm);
    for (int i = 0; i < n; i++) begin
      chk("dout", dout, e[n-1-i]);
      chk("dout_valid", dout_valid, 1);
      chk("busy", busy, 1);
      chk("done", done, dm[n-1-i]);
      tick();
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_dv"}, dout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_ready"}, load_ready, 1);
  endtask
  initial begin
    #2;
    idle_chk("rst");
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    load_valid = 1'b1; data = 16'hFFFF; len = 5'd4;
    tick();
    load_valid = 1'b0;
    idle_chk("rst_load_ignored");
    #2 rst_n = 1'b1;
    tick();
    idle_chk("post_rst");
    offer(16'h000B, 5'd4, 1'b0);
    run(32'b1011, 4, 32'b0001);
    idle_chk("single_end");
    offer(16'h000B, 5'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_a_dout", dout, (i == 1) ? 0 : 1);
      chk("b2b_a_done", done, (i == 3) ? 1 : 0);
      chk("b2b_a_ready", load_ready, (i == 3) ? 1 : 0);
      if (i == 3) begin
        data = 16'h0006; len = 5'd3; load_valid = 1'b1;
      end
      tick();
    end
    load_valid = 1'b0;
    run(32'b110, 3, 32'b001);
    idle_chk("b2b_end");
    offer(16'h000B, 5'd4, 1'b1);
    for (int i = 0; i < 12; i++) begin
      stop = (i == 5 || i == 11);
      #0;
      chk("loop_dout", dout, (i % 4 == 1) ? 0 : 1);
      chk("loop_dv", dout_valid, 1);
      chk("loop_done", done, (i == 11) ? 1 : 0);
      chk("loop_ready", load_ready, (i == 11) ? 1 : 0);
      tick();
    end
    stop = 1'b0;
    idle_chk("loop_end");
    offer(16'h0001, 5'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("len1_dout", dout, 1);
      chk("len1_done", done, 0);
      tick();
    end
    stop = 1'b1;
    #0;
    chk("len1_stop_dout", dout, 1);
    chk("len1_stop_done", done, 1);
    tick();
    stop = 1'b0;
    idle_chk("len1_end");
    offer(16'hFFFF, 5'd0, 1'b0);
    chk("len0_err", err, 1);
    idle_chk("len0");
    tick();
    chk("len0_err_clear", err, 0);
    offer(16'h8001, 5'd31, 1'b0);
    run(32'h8001, 16, 32'h0001);
    idle_chk("clamp_end");
    offer(16'h00A5, 5'd8, 1'b0);
    chk("rst_mid_b1", dout, 1);
    tick();
    chk("rst_mid_b2_dv", dout_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dv", dout_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dout", dout, 0);
    #2 rst_n = 1'b1;
    tick();
    idle_chk("rst_mid_idle");
    offer(16'h0005, 5'd3, 1'b0);
    run(32'b101, 3, 32'b001);
    idle_chk("after_rst_end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial bit-stream generator: the transmit-side counterpart of the serial sequence detector. It accepts a word of 1..W bits through a valid/ready load handshake and shifts it out MSB-first, one bit per clock. A loop mode repeats the word continuously. It drives detector benches and any block that consumes a serial din.

Parameters:
W, 16, maximum word length in bits (W >= 2)
LW, 5, width of len input; must satisfy 2^LW > W

Ports:
clk  input  1  system clock, all flops on rising edge
rst_n  input  1  reset, asynchronous, active-low
load_valid  input  1  word offered on data/len/loop
load_ready  output  1  block can accept a word this cycle
data  input  W  word to send; bits [len-1:0] used
len  input  LW  number of bits to send
loop  input  1  repeat word until stop, sampled at accept
stop  input  1  end loop mode at next word boundary
dout  output  1  serial bit
dout_valid  output  1  dout carries a bit this cycle
busy  output  1  word in progress
done  output  1  one-cycle pulse with last bit of a non-looping word
err  output  1  one-cycle pulse: accepted word had len==0

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE. Shift reg=0. Bit counter=0. Loop flag=0. dout=0, dout_valid=0, busy=0, done=0, err=0. Loads presented while rst_n is low are ignored.
- States: IDLE and SHIFT.
- load_ready is combinational. It is 1 in IDLE. In SHIFT it is 1 only in the last-bit cycle and only when the word will not repeat (loop flag=0, or stop=1).
- Accept: load_valid & load_ready at rising edge k.
  - data, len and loop are captured.
  - len>W is clamped to W.
  - len==0: no bits are sent. err=1 during cycle k+1. State stays or returns IDLE.
- Latency: first bit data[len-1] appears on dout with dout_valid=1 in the cycle after edge k. Bit i of n is presented in cycle k+i. Order is data[len-1] down to data[0].
- dout=0 whenever dout_valid=0. busy equals dout_valid.
- Last bit, non-looping: done=1 in the same cycle as the last bit.
  - If a new word is accepted at that edge, its first bit follows in the next cycle with no gap.
  - Otherwise the next state is IDLE.
- Loop: after the last bit, the captured word restarts at data[len-1] in the next cycle with no gap.
  - stop is sampled in the last-bit cycle. If stop=1, that pass is final: done=1 and load_ready=1.
  - stop asserted mid-word is not latched; it must be held through the last-bit cycle to take effect.
- len==1: every word is a single cycle. done pulses each word. In loop mode dout is held constant.
- Counter: down-counter of LW bits loaded with the clamped len-1. The last-bit condition is counter==0. No wrap below zero.
- Reset mid-word: output is truncated immediately (asynchronous). After release the block waits in IDLE and does not resume.
- Inputs data/len/loop are don't-care except at accept.

Test Plan:
- data=16'h000B, len=4, loop=0, accepted at edge 0 -> cycles 1..4: dout=1,0,1,1; dout_valid=1; done=1 only in cycle 4. Cycle 5: dout_valid=0, busy=0.
- Back-to-back: word A=4'b1011 then B=3'b110 offered in A's last cycle -> stream 1,0,1,1,1,1,0 with no gap. done pulses in cycles 4 and 7.
- Loop 4'b1011 for 3 passes, stop=1 in cycle 12 -> dout=101110111011, then IDLE. done only in cycle 12. The connected detector flags each 1011 occurrence, including overlaps.
- len=0 accepted -> err=1 for one cycle, dout_valid stays 0, load_ready=1 next cycle.
- len=31 with W=16, data=16'h8001 -> 16 bits: 1, fourteen 0s, 1. done on bit 16.
- rst_n low at bit 2 of an 8-bit word -> dout, dout_valid and busy go 0 without waiting for clk. After release: IDLE, and a new word is accepted normally.
